// File: rtl/mem_cache_ctrl_if.sv
// mem_cache_ctrl_if: MEM-stage request port and SRAM-controller port of the read cache
interface mem_cache_ctrl_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sramRead;
  logic        sramWrite;
  logic [31:0] sramAddr;
  logic [31:0] sramWData;
  logic [63:0] sramRData;
  logic        sramReady;
  modport slave (
    input  memRead, memWrite, address, wdata, sramRData, sramReady,
    output rdata, ready, sramRead, sramWrite, sramAddr, sramWData
  );
  modport master (
    output memRead, memWrite, address, wdata, sramRData, sramReady,
    input  rdata, ready, sramRead, sramWrite, sramAddr, sramWData
  );
endinterface

// File: rtl/mem_cache_ctrl.sv
// mem_cache_ctrl: 2-way set-associative write-through read cache in front of the SRAM controller.
// Define CACHE_STATS_EN to add saturating hitCount/missCount outputs.
module mem_cache_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          INDEX_W   = 6,
  parameter int          TAG_W     = 10
) (
  input  logic            clk,
  input  logic            rst,
  mem_cache_ctrl_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]     hitCount,
  output logic [15:0]     missCount
`endif
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int OFF_W = INDEX_W + TAG_W + 3;
  typedef enum logic [1:0] {IDLE, MISS, WRITE} state_t;
  state_t state, state_n;
  logic [SETS-1:0]  v0, v1, lru;
  logic [TAG_W-1:0] t0 [SETS];
  logic [TAG_W-1:0] t1 [SETS];
  logic [63:0]      d0 [SETS];
  logic [63:0]      d1 [SETS];
  logic [31:0]      off;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             wsel, hit0, hit1, hit, rd_hit, fill, unused_off;
  logic [63:0]      hblk;
  assign off        = bus.address - BASE_ADDR;
  assign idx        = off[INDEX_W+2:3];
  assign tag        = off[OFF_W-1:INDEX_W+3];
  assign wsel       = off[2];
  assign unused_off = ^{off[31:OFF_W], off[1:0]};
  assign hit0       = v0[idx] && t0[idx] == tag;
  assign hit1       = v1[idx] && t1[idx] == tag;
  assign hit        = hit0 || hit1;
  assign hblk       = hit1 ? d1[idx] : d0[idx];
  assign rd_hit     = state == IDLE && !bus.memWrite && bus.memRead && hit;
  assign fill       = state == MISS && bus.sramReady;
  assign bus.sramAddr  = bus.address;
  assign bus.sramWData = bus.wdata;
  always_comb begin
    state_n       = state;
    bus.ready     = 1'b1;
    bus.rdata     = '0;
    bus.sramRead  = 1'b0;
    bus.sramWrite = 1'b0;
    case (state)
      IDLE: begin
        if (bus.memWrite) begin
          bus.ready     = 1'b0;
          bus.sramWrite = 1'b1;
          state_n       = WRITE;
        end else if (bus.memRead) begin
          bus.ready    = hit;
          bus.sramRead = !hit;
          bus.rdata    = hit ? (wsel ? hblk[63:32] : hblk[31:0]) : '0;
          state_n      = hit ? IDLE : MISS;
        end
      end
      MISS: begin
        bus.sramRead = 1'b1;
        bus.ready    = bus.sramReady;
        bus.rdata    = bus.sramReady ? (wsel ? bus.sramRData[63:32] : bus.sramRData[31:0]) : '0;
        state_n      = bus.sramReady ? IDLE : MISS;
      end
      WRITE: begin
        bus.sramWrite = 1'b1;
        bus.ready     = bus.sramReady;
        state_n       = bus.sramReady ? IDLE : WRITE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      v0    <= '0;
      v1    <= '0;
      lru   <= '0;
    end else begin
      state <= state_n;
      if (rd_hit) lru[idx] <= hit0;
      if (state == IDLE && bus.memWrite) begin
        if (hit0) v0[idx] <= 1'b0;
        if (hit1) v1[idx] <= 1'b0;
      end
      if (fill) begin
        if (lru[idx]) v1[idx] <= 1'b1;
        else v0[idx] <= 1'b1;
        lru[idx] <= ~lru[idx];
      end
    end
  end
  // Tag/data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill && !lru[idx]) begin
      t0[idx] <= tag;
      d0[idx] <= bus.sramRData;
    end
    if (fill && lru[idx]) begin
      t1[idx] <= tag;
      d1[idx] <= bus.sramRData;
    end
  end
`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if (rd_hit && hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
      if (fill && missCount != 16'hFFFF) missCount <= missCount + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_cache_ctrl.sv
// tb_mem_cache_ctrl: directed test of mem_cache_ctrl against a recency-stamp cache model
module tb_mem_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_cache_ctrl_if bus();
`ifdef CACHE_STATS_EN
  logic [15:0] hitCount, missCount;
  mem_cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus), .hitCount(hitCount), .missCount(missCount));
`else
  mem_cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  int vecs = 0;
  int errs = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: per set two lines with a recency stamp; the older stamp is the victim.
  bit          mv [2][64];
  logic [9:0]  mt [2][64];
  logic [63:0] md [2][64];
  int          ms [2][64];
  int          tick = 0;
  int          busy = 0;
  int          mhits = 0;
  int          mmiss = 0;
  function automatic int mset(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return int'((o / 8) % 64);
  endfunction
  function automatic logic [9:0] mtag(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return 10'((o / 512) % 1024);
  endfunction
  function automatic int mway(input logic [31:0] a);
    int s;
    s = mset(a);
    for (int w = 0; w < 2; w++) if (mv[w][s] && mt[w][s] == mtag(a)) return w;
    return -1;
  endfunction
  function automatic logic [31:0] pick(input logic [63:0] b, input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return ((o / 4) % 2 == 1) ? b[63:32] : b[31:0];
  endfunction
  always @(posedge clk) begin
    int s, w, v;
    s = mset(bus.address);
    w = mway(bus.address);
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        mv[0][i] = 0; mv[1][i] = 0; ms[0][i] = 0; ms[1][i] = 0;
      end
      busy = 0; mhits = 0; mmiss = 0;
    end else if (busy == 1) begin
      if (bus.sramReady) begin
        v = (ms[0][s] <= ms[1][s]) ? 0 : 1;
        mv[v][s] = 1; mt[v][s] = mtag(bus.address); md[v][s] = bus.sramRData;
        ms[v][s] = ++tick;
        if (mmiss < 65535) mmiss++;
        busy = 0;
      end
    end else if (busy == 2) begin
      if (bus.sramReady) busy = 0;
    end else if (bus.memWrite) begin
      if (w >= 0) mv[w][s] = 0;
      busy = 2;
    end else if (bus.memRead) begin
      if (w >= 0) begin
        ms[w][s] = ++tick;
        if (mhits < 65535) mhits++;
      end else busy = 1;
    end
  end
  always @(negedge clk) begin
    int w;
    logic        e_ready, e_rd, e_wr;
    logic [31:0] e_data;
    if (!rst) begin
      w = mway(bus.address);
      e_ready = 1; e_rd = 0; e_wr = 0; e_data = 0;
      if (busy == 1) begin
        e_rd = 1; e_ready = bus.sramReady;
        e_data = bus.sramReady ? pick(bus.sramRData, bus.address) : 32'h0;
      end else if (busy == 2) begin
        e_wr = 1; e_ready = bus.sramReady;
      end else if (bus.memWrite) begin
        e_ready = 0; e_wr = 1;
      end else if (bus.memRead) begin
        if (w >= 0) e_data = pick(md[w][mset(bus.address)], bus.address);
        else begin e_ready = 0; e_rd = 1; end
      end
      chk("ready", bus.ready, e_ready);
      chk("rdata", bus.rdata, e_data);
      chk("sramRead", bus.sramRead, e_rd);
      chk("sramWrite", bus.sramWrite, e_wr);
      chk("sramAddr", bus.sramAddr, bus.address);
      chk("sramWData", bus.sramWData, bus.wdata);
`ifdef CACHE_STATS_EN
      chk("hitCount", hitCount, 64'(mhits));
      chk("missCount", missCount, 64'(mmiss));
`endif
    end
  end
  logic [31:0] l_rdata;
  logic        l_ready, l_sr0;
  int          l_low;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [31:0] a, input int lat, input logic [63:0] blk);
    bit miss;
    bus.address = a; bus.memRead = 1; l_low = 0;
    miss = mway(a) < 0;
    @(negedge clk);
    l_sr0 = bus.sramRead;
    if (miss) begin
      for (int i = 0; i < lat; i++) begin
        if (i > 0) @(negedge clk);
        if (!bus.ready) l_low++;
        cyc;
      end
      bus.sramReady = 1; bus.sramRData = blk;
      @(negedge clk);
    end
    l_rdata = bus.rdata; l_ready = bus.ready;
    cyc;
    bus.sramReady = 0; bus.memRead = 0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int lat);
    bus.address = a; bus.wdata = d; bus.memWrite = 1; l_low = 0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (bus.sramWrite && !bus.ready) l_low++;
      cyc;
    end
    bus.sramReady = 1;
    @(negedge clk);
    l_ready = bus.ready;
    cyc;
    bus.sramReady = 0; bus.memWrite = 0;
  endtask
  initial begin
    bus.memRead = 0; bus.memWrite = 0; bus.address = 0; bus.wdata = 0;
    bus.sramRData = 0; bus.sramReady = 0;
    repeat (2) cyc;
    rst = 0;
    @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_sramRead", bus.sramRead, 0);
    chk("rst_sramWrite", bus.sramWrite, 0);
    cyc;
    rd(32'h400, 5, 64'h0000_0022_0000_0011);
    chk("miss_low", l_low, 5);
    chk("miss_rdata", l_rdata, 32'h11);
    chk("miss_ready", l_ready, 1);
    rd(32'h404, 0, 0);
    chk("hit_rdata", l_rdata, 32'h22);
    chk("hit_ready", l_ready, 1);
    chk("hit_sramRead", l_sr0, 0);
    rd(32'h600, 3, 64'h0000_00BB_0000_00AA);
    chk("tag1_low", l_low, 3);
    chk("tag1_rdata", l_rdata, 32'hAA);
    rd(32'h400, 0, 0);
    chk("rehit_low", l_low, 0);
    rd(32'h800, 3, 64'h0000_00DD_0000_00CC);
    chk("tag2_low", l_low, 3);
    rd(32'h400, 0, 0);
    chk("keep_low", l_low, 0);
    chk("keep_rdata", l_rdata, 32'h11);
    rd(32'h604, 3, 64'h0000_00BB_0000_00AA);
    chk("evicted_low", l_low, 3);
    chk("evicted_rdata", l_rdata, 32'hBB);
    wr(32'h404, 32'hDEAD, 4);
    chk("wr_low", l_low, 4);
    chk("wr_ready", l_ready, 1);
    rd(32'h404, 2, 64'h0000_DEAD_0000_0011);
    chk("postwr_sramRead", l_sr0, 1);
    chk("postwr_rdata", l_rdata, 32'hDEAD);
    rst = 1; cyc; rst = 0;
    wr(32'h800, 32'hBEEF, 2);
    rd(32'h800, 3, 64'h0000_0001_0000_BEEF);
    chk("nowa_low", l_low, 3);
    bus.address = 32'h400; bus.memRead = 1;
    cyc; cyc;
    rst = 1; bus.memRead = 0; cyc; rst = 0;
    @(negedge clk);
    chk("rstmiss_ready", bus.ready, 1);
    chk("rstmiss_sramRead", bus.sramRead, 0);
    cyc;
    bus.sramReady = 1; bus.sramRData = 64'h0000_0099_0000_0088;
    @(negedge clk);
    chk("late_rdata", bus.rdata, 0);
    cyc;
    bus.sramReady = 0;
    rd(32'h400, 2, 64'h0000_0022_0000_0011);
    chk("after_rst_low", l_low, 2);
`ifdef CACHE_STATS_EN
    rst = 1; cyc; rst = 0;
    @(negedge clk);
    chk("rst_hitCount", hitCount, 0);
    chk("rst_missCount", missCount, 0);
    cyc;
    rd(32'h400, 2, 64'h0000_0022_0000_0011);
    rd(32'h404, 0, 0);
    rd(32'h400, 0, 0);
    rd(32'h404, 0, 0);
    rd(32'h600, 2, 64'h0000_00BB_0000_00AA);
    @(negedge clk);
    chk("hitCount", hitCount, 3);
    chk("missCount", missCount, 2);
    cyc;
`endif
    repeat (2) cyc;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
